// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file arbiter.
// rf_cmd_t is the registered command presented to the register file.
package regfile_pkg;

  localparam int RF_ADDR_W = 4;
  localparam int RF_DATA_W = 16;

  localparam logic RF_READ  = 1'b0;
  localparam logic RF_WRITE = 1'b1;

  // Wide enough for up to 4 requesters.
  typedef logic [1:0] req_idx_t;

  typedef struct packed {
    logic                 en;
    logic                 rw;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] wdata;
  } rf_cmd_t;

endpackage

// File: rtl/regfile_arbiter_rr_arbiter.sv
// Purpose: one-hot grant from a request vector, round-robin from ptr (REGARB_FIXED_PRIO_EN: lowest index wins).
// Latency: purely combinational.
// Backpressure: none; losers simply keep requesting.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output logic [NUM_REQ-1:0] gnt
);

`ifdef REGARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
      end
    end
  end
`else
  logic found;
  int   slot;

  // slot is the requester's distance from ptr in the rotated order; smallest requesting slot wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    slot  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        slot = (k >= int'(ptr)) ? (k - int'(ptr)) : (k - int'(ptr) + NUM_REQ);
        if (!found && req[k] && (slot == i)) begin
          gnt[k] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_arbiter.sv
// Purpose: shares the single-port register file among NUM_REQ requesters; REGARB_FIXED_PRIO_EN selects fixed priority.
// Latency: command 1 cycle after grant, read data + o_rvalid 2 cycles after grant.
// Backpressure: a requester waits with i_req held until o_gnt; one transfer accepted per cycle.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ-1:0]          i_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   i_wdata,
  output logic [NUM_REQ-1:0]          o_gnt,
  output logic [NUM_REQ-1:0]          o_rvalid,
  output logic [DATA_W-1:0]           o_rdata,
  output logic                        o_rf_en,
  output logic                        o_rf_rw,
  output logic [ADDR_W-1:0]           o_rf_addr,
  output logic [DATA_W-1:0]           o_rf_wdata,
  input  logic [DATA_W-1:0]           i_rf_rdata
);

  localparam req_idx_t           LAST_IDX = req_idx_t'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [NUM_REQ-1:0] arb_gnt;
  req_idx_t           ptr;
  req_idx_t           gnt_idx;
  logic               accept;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  rf_cmd_t            cmd_q;
  req_idx_t           owner_q;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [DATA_W-1:0]  rdata_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req (i_req),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  assign o_gnt  = i_rst ? '0 : arb_gnt;
  assign accept = |o_gnt;

  always_comb begin
    gnt_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (o_gnt[k]) begin
        gnt_idx   = req_idx_t'(k);
        sel_we    = i_we[k];
        sel_addr  = i_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = i_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef REGARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end
  end
`endif

  // Command stage: address holds when idle so the register-file address bus does not toggle needlessly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cmd_q   <= '0;
      owner_q <= '0;
    end else begin
      cmd_q.en    <= accept;
      cmd_q.rw    <= accept ? sel_we : RF_READ;
      cmd_q.wdata <= accept ? sel_wdata : '0;
      if (accept) begin
        cmd_q.addr <= sel_addr;
        owner_q    <= gnt_idx;
      end
    end
  end

  // Response stage: register-file data is valid at the end of the read command cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else if (cmd_q.en && (cmd_q.rw == RF_READ)) begin
      rvalid_q <= ONE_HOT0 << owner_q;
      rdata_q  <= i_rf_rdata;
    end else begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end
  end

  assign o_rf_en    = cmd_q.en;
  assign o_rf_rw    = cmd_q.rw;
  assign o_rf_addr  = cmd_q.addr;
  assign o_rf_wdata = cmd_q.wdata;
  assign o_rvalid   = rvalid_q;
  assign o_rdata    = rdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed stimulus, read responses checked by a scoreboard monitor.
module tb_regfile_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic [1:0]  i_req;
  logic [1:0]  i_we;
  logic [7:0]  i_addr;
  logic [31:0] i_wdata;
  logic [1:0]  o_gnt;
  logic [1:0]  o_rvalid;
  logic [15:0] o_rdata;
  logic        o_rf_en;
  logic        o_rf_rw;
  logic [3:0]  o_rf_addr;
  logic [15:0] o_rf_wdata;
  logic [15:0] i_rf_rdata;

  regfile_arbiter #(
    .NUM_REQ (2),
    .ADDR_W  (4),
    .DATA_W  (16)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_we       (i_we),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_gnt      (o_gnt),
    .o_rvalid   (o_rvalid),
    .o_rdata    (o_rdata),
    .o_rf_en    (o_rf_en),
    .o_rf_rw    (o_rf_rw),
    .o_rf_addr  (o_rf_addr),
    .o_rf_wdata (o_rf_wdata),
    .i_rf_rdata (i_rf_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Register-file model: synchronous write, combinational read.
  logic [15:0] mem [16];
  always @(posedge i_clk) if (o_rf_en && o_rf_rw) mem[o_rf_addr] <= o_rf_wdata;
  assign i_rf_rdata = mem[o_rf_addr];

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  vld;
    logic [15:0] data;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One cycle of stimulus; eg is the hand-computed grant, er the data a granted read must return.
  task automatic drive(input logic [1:0] req, input logic [1:0] we,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1,
                       input logic [1:0] eg, input logic [15:0] er);
    i_req   = req;
    i_we    = we;
    i_addr  = {a1, a0};
    i_wdata = {d1, d0};
    @(negedge i_clk);
    chk("gnt", 32'(o_gnt), 32'(eg));
    if ((eg[0] && !we[0]) || (eg[1] && !we[1])) sb.push_back('{eg, er, cyc});
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 4'h0, 4'h0, 16'h0, 16'h0, 2'b00, 16'h0);
  endtask

  always @(negedge i_clk) begin
    if ((|o_rvalid) === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_rvalid: got rvalid=%b rdata=%h, required no response (cycle %0d)", o_rvalid, o_rdata, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rvalid", 32'(o_rvalid), 32'(mon_e.vld));
        chk("rdata", 32'(o_rdata), 32'(mon_e.data));
        chk("rlatency", 32'(cyc), 32'(mon_e.acc_cyc + 2));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  logic [15:0] ev;
  logic [1:0]  g_a;
  logic [1:0]  g_b;

  initial begin
    i_rst = 1'b1; i_req = 2'b11; i_we = 2'b00; i_addr = '0; i_wdata = '0;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("rst_gnt", 32'(o_gnt), 32'h0);
    chk("rst_rf_en", 32'(o_rf_en), 32'h0);
    chk("rst_rvalid", 32'(o_rvalid), 32'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // First grant after reset goes to requester 0; both preload writes.
    drive(2'b11, 2'b11, 4'h0, 4'hF, 16'h0000, 16'hFFFF, 2'b01, 16'h0);
    drive(2'b10, 2'b11, 4'h0, 4'hF, 16'h0000, 16'hFFFF, 2'b10, 16'h0);
    for (int k = 1; k < 15; k++)
      drive(2'b01, 2'b01, 4'(k), 4'h0, {4{4'(k)}}, 16'h0, 2'b01, 16'h0);

    // Single write then read-after-write of the same register.
    drive(2'b01, 2'b01, 4'h3, 4'h0, 16'hBEEF, 16'h0, 2'b01, 16'h0);
    chk("wr_rf_en", 32'(o_rf_en), 32'h1);
    chk("wr_rf_rw", 32'(o_rf_rw), 32'h1);
    chk("wr_rf_addr", 32'(o_rf_addr), 32'h3);
    chk("wr_rf_wdata", 32'(o_rf_wdata), 32'hBEEF);
    drive(2'b01, 2'b00, 4'h3, 4'h0, 16'h0, 16'h0, 2'b01, 16'hBEEF);
    chk("rd_rf_en", 32'(o_rf_en), 32'h1);
    chk("rd_rf_rw", 32'(o_rf_rw), 32'h0);
    chk("rd_rf_wdata", 32'(o_rf_wdata), 32'h0);

    // Requester 1 write moves the pointer back to 0 before contention.
    drive(2'b10, 2'b10, 4'h0, 4'h2, 16'h0, 16'h2222, 2'b10, 16'h0);

`ifdef REGARB_FIXED_PRIO_EN
    g_a = 2'b01; g_b = 2'b01;
`else
    g_a = 2'b01; g_b = 2'b10;
`endif
    for (int r = 0; r < 2; r++) begin
      drive(2'b11, 2'b00, 4'h1, 4'h2, 16'h0, 16'h0, g_a, g_a[0] ? 16'h1111 : 16'h2222);
      drive(2'b11, 2'b00, 4'h1, 4'h2, 16'h0, 16'h0, g_b, g_b[0] ? 16'h1111 : 16'h2222);
    end

    // Back-to-back reads of every register by requester 1.
    for (int k = 0; k < 16; k++) begin
      ev = (k == 3) ? 16'hBEEF : {4{4'(k)}};
      drive(2'b10, 2'b00, 4'h0, 4'(k), 16'h0, 16'h0, 2'b10, ev);
    end
    idle();
    idle();
    chk("idle_rf_en", 32'(o_rf_en), 32'h0);
    chk("idle_rf_addr_hold", 32'(o_rf_addr), 32'hF);

    // Reset the cycle after a read is accepted: response must be dropped.
    drive(2'b01, 2'b00, 4'h5, 4'h0, 16'h0, 16'h0, 2'b01, 16'h0);
    sb.delete();
    i_rst = 1'b1;
    i_req = 2'b11;
    @(negedge i_clk);
    chk("rst_mid_gnt", 32'(o_gnt), 32'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("rst_mid_rf_en", 32'(o_rf_en), 32'h0);
    // Pointer back at 0, so requester 0 wins even though it was granted last.
    drive(2'b11, 2'b00, 4'h4, 4'h6, 16'h0, 16'h0, 2'b01, 16'h4444);

    // Idle: pointer holds across 5 empty cycles.
    idle();
    for (int k = 0; k < 4; k++) begin
      idle();
      chk("idle_en", 32'(o_rf_en), 32'h0);
      chk("idle_rw", 32'(o_rf_rw), 32'h0);
    end
`ifdef REGARB_FIXED_PRIO_EN
    drive(2'b11, 2'b00, 4'h7, 4'h8, 16'h0, 16'h0, 2'b01, 16'h7777);
`else
    drive(2'b11, 2'b00, 4'h7, 4'h8, 16'h0, 16'h0, 2'b10, 16'h8888);
`endif

    for (int k = 0; k < 4; k++) idle();
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the single-port 16x16 register file (one address, one r/w strobe, one data bus) between NUM_REQ requesters, e.g. operand fetch and writeback.
- Arbitrates with a valid/grant handshake, issues one registered register-file command per cycle, and returns read data tagged to the requester that issued the read.
- Sits between the CPU control/datapath and `registers`.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- ADDR_W, 4, register-file address width
- DATA_W, 16, register data width

Ports:
- i_clk  in  1  system clock; all state on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_req  in  NUM_REQ  per-requester request valid
- i_we  in  NUM_REQ  per-requester access type: 1 = write, 0 = read
- i_addr  in  NUM_REQ*ADDR_W  per-requester address; requester k uses slice [k*ADDR_W +: ADDR_W]
- i_wdata  in  NUM_REQ*DATA_W  per-requester write data, sliced as for i_addr
- o_gnt  out  NUM_REQ  one-hot grant; combinational, same cycle as acceptance
- o_rvalid  out  NUM_REQ  one-hot read-data-valid pulse
- o_rdata  out  DATA_W  read data; meaningful only while o_rvalid is nonzero
- o_rf_en  out  1  command valid toward the register file
- o_rf_rw  out  1  register-file r/w: 1 = write, 0 = read
- o_rf_addr  out  ADDR_W  register-file address
- o_rf_wdata  out  DATA_W  register-file write data
- i_rf_rdata  in  DATA_W  register-file read data (o_data of `registers`)

Behaviour:
- Reset: all outputs are 0 one cycle after i_rst is sampled high. Round-robin pointer is 0. In-flight reads are dropped and produce no o_rvalid.
- Handshake: a transfer is accepted in a cycle where i_req[k] && o_gnt[k].
  - Requesters hold i_we, i_addr and i_wdata stable while i_req is high and not yet granted.
  - A requester that keeps i_req high after a grant makes a new request.
- Arbitration: every cycle, at most one o_gnt bit is set.
  - Round-robin search starts at index ptr, wrapping modulo NUM_REQ.
  - On a grant to k, ptr becomes (k+1) mod NUM_REQ. With no requests, ptr holds.
  - o_gnt is never set for a requester whose i_req is low.
  - o_gnt is forced to 0 while i_rst is high.
- Command stage (registered): the cycle after acceptance, o_rf_en=1 and o_rf_rw/o_rf_addr/o_rf_wdata carry the accepted fields.
  - In cycles with no accepted transfer: o_rf_en=0, o_rf_rw=0, o_rf_wdata=0; o_rf_addr holds its last value.
  - o_rf_rw is never 1 while o_rf_en is 0.
- Response stage: i_rf_rdata is sampled at the end of the command cycle.
  - For a read command, o_rdata is set to the sampled data and o_rvalid[k] pulses for 1 cycle, where k is the owning requester.
  - Read latency is 2 cycles from acceptance. Writes produce no response.
- Throughput: one accepted transfer per cycle, with no bubbles. Back-to-back reads give back-to-back o_rvalid pulses, in acceptance order.
- Read-after-write: the register file orders accesses. A read accepted in the cycle after a write to the same address returns the new value.
- Width rules: the address is ADDR_W bits with no range check; all 16 registers are addressable.

Optional Feature:
- Macro: REGARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins. ptr is removed; requester 0 (operand fetch) can starve the others.
- Undefined (default): round-robin as described above.
- Handshake, latency and reset behaviour are identical in both builds.

Decomposition:
- Package regfile_pkg holds:
  - constants RF_ADDR_W=4 and RF_DATA_W=16;
  - RF_READ=1'b0 and RF_WRITE=1'b1;
  - typedef rf_cmd_t {en, rw, addr, wdata} plus a requester-index typedef.
- One sub-module, rr_arbiter: request vector and pointer in, one-hot grant out. It holds the REGARB_FIXED_PRIO_EN switch.
- Command and response pipeline registers stay in the top module.

Test Plan:
- Reset: i_rst=1 for 2 cycles with i_req=2'b11 -> o_gnt=0, o_rf_en=0, o_rvalid=0. After release, the first grant goes to requester 0.
- Single write/read: req0 writes addr 4'h3, data 16'hBEEF; next cycle req0 reads 4'h3.
  - o_rf_rw=1 for one cycle, then 0.
  - o_rvalid=2'b01 with o_rdata=16'hBEEF exactly 2 cycles after the read grant.
- Contention: both requesters read continuously (addr 4'h1 and 4'h2, preloaded 16'h1111 and 16'h2222).
  - Grants alternate 01, 10, 01, 10.
  - o_rdata alternates 1111/2222 with matching o_rvalid bits.
  - With REGARB_FIXED_PRIO_EN defined, every grant is 01.
- Back-to-back reads: req1 reads 4'h0 through 4'hF on consecutive cycles -> 16 consecutive o_rvalid=2'b10 pulses, in order, with no gaps.
- Reset mid-operation: assert i_rst the cycle after a read is accepted -> no o_rvalid pulse follows, and ptr returns to 0.
- Idle hold: i_req=0 for 5 cycles -> o_gnt=0, o_rf_en=0, o_rf_rw=0; ptr is unchanged, so the next winner is the same as before the idle period.
